// File: rtl/ifu_rd_arbiter.sv
// ifu_rd_arbiter
//   Round-robin arbiter sharing one memory read port between the IFU fetch
//   port (M0) and a secondary reader such as the LSU or debug port (M1).
//   Only one transaction is outstanding at a time: IDLE -> ADDR -> DATA -> IDLE.
//   When the IFU pipeline is flushed, an in-flight IFU response is still taken
//   from the slave but is not forwarded, so the slave never stalls.
//
// Ports
//   CLK, RST                 clock; asynchronous active-high reset
//   M0_AR*/M0_R*, M0_FLUSH   IFU request/response channel and flush
//   M1_AR*/M1_R*             port-1 request/response channel
//   S_AR*/S_R*               slave read port (S_ARADDR/S_ARVALID are registered)
module ifu_rd_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] M0_ARADDR,
  input  logic          M0_ARVALID,
  output logic          M0_ARREADY,
  output logic          M0_RVALID,
  input  logic          M0_RREADY,
  output logic [DW-1:0] M0_RDATA,
  input  logic          M0_FLUSH,
  input  logic [AW-1:0] M1_ARADDR,
  input  logic          M1_ARVALID,
  output logic          M1_ARREADY,
  output logic          M1_RVALID,
  input  logic          M1_RREADY,
  output logic [DW-1:0] M1_RDATA,
  output logic [AW-1:0] S_ARADDR,
  output logic          S_ARVALID,
  input  logic          S_ARREADY,
  input  logic          S_RVALID,
  output logic          S_RREADY,
  input  logic [DW-1:0] S_RDATA
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   owner;       // 0 = M0 owns the transaction, 1 = M1
  logic   last_grant;  // port granted most recently; ties go to the other one
  logic   drop;        // IFU transaction cancelled by a flush, discard its response

  logic req0, req1, gnt0, gnt1, idle, in_data;
  logic flush_own, drop_now, own_rready;

  // A flushed IFU request must not be issued.
  assign req0 = M0_ARVALID & ~M0_FLUSH;
  assign req1 = M1_ARVALID;

  // Outputs are forced quiet while reset is held, even though state is IDLE.
  assign idle    = (state == IDLE) & ~RST;
  assign in_data = (state == DATA) & ~RST;

  assign gnt1 = idle & req1 & (~req0 | ~last_grant);
  assign gnt0 = idle & req0 & ~gnt1;

  assign M0_ARREADY = gnt0;
  assign M1_ARREADY = gnt1;

  // A flush in the same cycle as the response must already suppress it,
  // so the registered drop flag is combined with the live flush.
  assign flush_own = M0_FLUSH & ~owner & ((state == ADDR) | (state == DATA));
  assign drop_now  = drop | flush_own;

  assign own_rready = owner ? M1_RREADY : M0_RREADY;

  assign M0_RVALID = in_data & ~drop_now & ~owner & S_RVALID;
  assign M1_RVALID = in_data & ~drop_now &  owner & S_RVALID;
  assign S_RREADY  = in_data & (drop_now | own_rready);

  // Response data is routed unqualified; RVALID marks when it is meaningful.
  assign M0_RDATA = S_RDATA;
  assign M1_RDATA = S_RDATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      drop       <= 1'b0;
      S_ARADDR   <= '0;
      S_ARVALID  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            S_ARADDR   <= gnt1 ? M1_ARADDR : M0_ARADDR;
            S_ARVALID  <= 1'b1;
            owner      <= gnt1;
            last_grant <= gnt1;
            drop       <= 1'b0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // Request stays up with a stable address until the slave takes it.
          if (flush_own) drop <= 1'b1;
          if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (flush_own) drop <= 1'b1;
          if (S_RVALID & S_RREADY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_rd_arbiter.sv
// Directed bench for ifu_rd_arbiter. Inputs change on the falling edge and
// outputs are sampled 1ns later, so registered outputs reflect the preceding
// rising edge and combinational outputs reflect the freshly driven inputs.
module tb_ifu_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
  logic          M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY, M0_FLUSH;
  logic          M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
  logic          S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [DW-1:0] M0_RDATA, M1_RDATA, S_RDATA;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ifu_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY), .M0_RDATA(M0_RDATA),
    .M0_FLUSH(M0_FLUSH),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY), .M1_RDATA(M1_RDATA),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (input drive point).
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    M0_ARADDR = '0; M0_ARVALID = 0; M0_RREADY = 0; M0_FLUSH = 0;
    M1_ARADDR = '0; M1_ARVALID = 0; M1_RREADY = 0;
    S_ARREADY = 0; S_RVALID = 0; S_RDATA = '0;
  endtask

  initial begin
    // ---- reset state; requests present must not be accepted in reset ----
    idle_inputs();
    RST = 1;
    M0_ARVALID = 1; M1_ARVALID = 1; S_RVALID = 1;
    #1;
    chk("rst_m0_arready", M0_ARREADY, 0);
    chk("rst_m1_arready", M1_ARREADY, 0);
    chk("rst_s_arvalid",  S_ARVALID, 0);
    chk("rst_s_araddr",   S_ARADDR, 0);
    chk("rst_s_rready",   S_RREADY, 0);
    cyc(); cyc();
    idle_inputs();
    RST = 0;

    // ---- 1: M0 only, immediate slave ----
    cyc();
    M0_ARVALID = 1; M0_ARADDR = 64'h8000_0000; M0_RREADY = 1;
    S_ARREADY = 1; S_RVALID = 1; S_RDATA = 64'h13;
    #1;
    chk("t1_m0_arready",  M0_ARREADY, 1);
    chk("t1_m1_arready",  M1_ARREADY, 0);
    chk("t1_s_arvalid_t", S_ARVALID, 0);
    chk("t1_idle_rready", S_RREADY, 0);
    cyc(); M0_ARVALID = 0; #1;
    chk("t1_s_arvalid",   S_ARVALID, 1);
    chk("t1_s_araddr",    S_ARADDR, 64'h8000_0000);
    chk("t1_addr_rvalid", M0_RVALID, 0);
    cyc(); #1;
    chk("t1_m0_rvalid",   M0_RVALID, 1);
    chk("t1_m0_rdata",    M0_RDATA, 64'h13);
    chk("t1_s_rready",    S_RREADY, 1);
    chk("t1_m1_rvalid",   M1_RVALID, 0);
    cyc(); #1;
    chk("t1_back_idle_v", S_ARVALID, 0);
    chk("t1_back_idle_r", S_RREADY, 0);
    chk("t1_back_idle_m", M0_RVALID, 0);

    // ---- 3: M1 request, slave stalls ARREADY for 4 cycles ----
    cyc(); idle_inputs();
    M1_ARVALID = 1; M1_ARADDR = 64'hABC;
    #1;
    chk("t3_m1_arready", M1_ARREADY, 1);
    chk("t3_m0_arready", M0_ARREADY, 0);
    M0_ARVALID = 1; M0_ARADDR = 64'h5555;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      S_ARREADY = (i == 5);
      #1;
      chk($sformatf("t3_s_arvalid_%0d", i), S_ARVALID, 1);
      chk($sformatf("t3_s_araddr_%0d", i),  S_ARADDR, 64'hABC);
      chk($sformatf("t3_no_ar_%0d", i),     {M0_ARREADY, M1_ARREADY}, 0);
    end
    cyc(); idle_inputs();
    S_RVALID = 1; S_RDATA = 64'hD00D; M1_RREADY = 1;
    #1;
    chk("t3_m1_rvalid", M1_RVALID, 1);
    chk("t3_m1_rdata",  M1_RDATA, 64'hD00D);
    chk("t3_m0_rvalid", M0_RVALID, 0);
    cyc(); idle_inputs(); #1;
    chk("t3_idle_v", S_ARVALID, 0);

    // ---- 4: flush during DATA, response comes later ----
    cyc(); M0_ARVALID = 1; M0_ARADDR = 64'h40; #1;
    chk("t4_m0_arready", M0_ARREADY, 1);
    cyc(); M0_ARVALID = 0; S_ARREADY = 1; #1;
    chk("t4_s_arvalid", S_ARVALID, 1);
    cyc(); S_ARREADY = 0; M0_FLUSH = 1; S_RVALID = 0; M0_RREADY = 0; #1;
    chk("t4_flush_rready", S_RREADY, 1);
    chk("t4_flush_rvalid", M0_RVALID, 0);
    cyc(); M0_FLUSH = 0; S_RVALID = 1; S_RDATA = 64'hBAD; #1;
    chk("t4_drop_rvalid", M0_RVALID, 0);
    chk("t4_drop_rready", S_RREADY, 1);
    cyc(); #1;
    chk("t4_idle_rready", S_RREADY, 0);
    chk("t4_idle_rvalid", M0_RVALID, 0);

    // ---- 4b: flush in the same cycle as the response handshake ----
    cyc(); idle_inputs(); M0_ARVALID = 1; M0_ARADDR = 64'h80; #1;
    chk("t4b_m0_arready", M0_ARREADY, 1);
    cyc(); M0_ARVALID = 0; S_ARREADY = 1; #1;
    cyc(); S_ARREADY = 0; S_RVALID = 1; M0_FLUSH = 1; #1;
    chk("t4b_rvalid", M0_RVALID, 0);
    chk("t4b_rready", S_RREADY, 1);
    cyc(); M0_FLUSH = 0; #1;
    chk("t4b_idle_rready", S_RREADY, 0);

    // ---- 5: flushed M0 request loses to M1; flush ignored for M1 ----
    cyc(); idle_inputs();
    M0_ARVALID = 1; M0_FLUSH = 1; M1_ARVALID = 1; M1_ARADDR = 64'h123;
    #1;
    chk("t5_m1_arready", M1_ARREADY, 1);
    chk("t5_m0_arready", M0_ARREADY, 0);
    cyc(); M0_ARVALID = 0; M1_ARVALID = 0; S_ARREADY = 1; #1;
    chk("t5_s_araddr", S_ARADDR, 64'h123);
    cyc(); S_ARREADY = 0; S_RVALID = 1; S_RDATA = 64'h77; M1_RREADY = 0; #1;
    chk("t5_m1_rvalid", M1_RVALID, 1);
    chk("t5_s_rready",  S_RREADY, 0);
    cyc(); M1_RREADY = 1; #1;
    chk("t5_m1_rvalid2", M1_RVALID, 1);
    chk("t5_s_rready2",  S_RREADY, 1);
    cyc(); idle_inputs(); #1;
    chk("t5_idle", S_RREADY, 0);

    // ---- 6: async reset in the middle of ADDR ----
    cyc(); M0_ARVALID = 1; M0_ARADDR = 64'h99; #1;
    chk("t6_m0_arready", M0_ARREADY, 1);
    cyc(); M0_ARVALID = 0; #1;
    chk("t6_s_arvalid", S_ARVALID, 1);
    #2 RST = 1; #1;
    chk("t6_async_arvalid", S_ARVALID, 0);
    chk("t6_async_araddr",  S_ARADDR, 0);
    cyc(); RST = 0;

    // ---- 2: both ports valid every cycle, six grants alternate from M0 ----
    M0_ARVALID = 1; M0_ARADDR = 64'h1000; M0_RREADY = 1;
    M1_ARVALID = 1; M1_ARADDR = 64'h2000; M1_RREADY = 1;
    S_ARREADY = 1; S_RVALID = 1; S_RDATA = 64'hCAFE;
    for (int g = 0; g < 6; g++) begin
      if (g != 0) cyc();
      #1;
      chk($sformatf("t2_g%0d_m0_ar", g), M0_ARREADY, (g % 2) == 0);
      chk($sformatf("t2_g%0d_m1_ar", g), M1_ARREADY, (g % 2) == 1);
      cyc(); #1;
      chk($sformatf("t2_g%0d_addr", g), S_ARADDR, ((g % 2) == 0) ? 64'h1000 : 64'h2000);
      chk($sformatf("t2_g%0d_no_ar", g), {M0_ARREADY, M1_ARREADY}, 0);
      cyc(); #1;
      chk($sformatf("t2_g%0d_rv", g), {M1_RVALID, M0_RVALID}, ((g % 2) == 0) ? 2'b01 : 2'b10);
    end
    cyc(); idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the sequence above stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
